// File: rtl/irq_arb_pkg.sv
// Shared types and the pairwise compare rule for the EDF tournament arbiter.
package irq_arb_pkg;

  // Keys are widened to this width before comparison so one function serves every PrioWidth.
  localparam int unsigned MaxPrioWidth = 64;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  // Pick the winner of one tree node. Side A always carries the lower line indices,
  // so "lower index wins" on a full tie means SEL_A.
  function automatic sel_e arbitrate(
    input logic                    valid_a,
    input logic                    valid_b,
    input logic [MaxPrioWidth-1:0] prio_a,
    input logic [MaxPrioWidth-1:0] prio_b,
    input logic                    late_a,
    input logic                    late_b,
    input logic                    signed_mode
  );
    sel_e sel;
    logic a_lt_b;
    logic b_lt_a;
    if (signed_mode) begin
      a_lt_b = $signed(prio_a) < $signed(prio_b);
      b_lt_a = $signed(prio_b) < $signed(prio_a);
    end else begin
      a_lt_b = prio_a < prio_b;
      b_lt_a = prio_b < prio_a;
    end
    sel = SEL_A;
    if (!valid_a) begin
      sel = valid_b ? SEL_B : SEL_A;
    end else if (valid_b) begin
      if (b_lt_a) begin
        sel = SEL_B;
      end else if (!a_lt_b && late_a && !late_b) begin
        sel = SEL_B;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/irq_arb_node.sv
// Combinational 2:1 compare/select cell of the arbitration tree.
module irq_arb_node
  import irq_arb_pkg::*;
#(
  parameter int unsigned PrioWidth  = 8,
  parameter int unsigned IdxWidth   = 5,
  parameter bit          SignedPrio = 1'b1
) (
  input  logic                 i_a_valid,
  input  logic                 i_a_late,
  input  logic [PrioWidth-1:0] i_a_prio,
  input  logic [IdxWidth-1:0]  i_a_idx,
  input  logic                 i_b_valid,
  input  logic                 i_b_late,
  input  logic [PrioWidth-1:0] i_b_prio,
  input  logic [IdxWidth-1:0]  i_b_idx,
  output logic                 o_valid,
  output logic                 o_late,
  output logic [PrioWidth-1:0] o_prio,
  output logic [IdxWidth-1:0]  o_idx
);

  logic [MaxPrioWidth-1:0] w_a_key;
  logic [MaxPrioWidth-1:0] w_b_key;
  sel_e                    w_sel;

  // Widen keys, choose a side, and force an empty result to all zeros.
  always_comb begin
    if (SignedPrio) begin
      w_a_key = MaxPrioWidth'($signed(i_a_prio));
      w_b_key = MaxPrioWidth'($signed(i_b_prio));
    end else begin
      w_a_key = MaxPrioWidth'(i_a_prio);
      w_b_key = MaxPrioWidth'(i_b_prio);
    end
    w_sel   = arbitrate(i_a_valid, i_b_valid, w_a_key, w_b_key, i_a_late, i_b_late, SignedPrio);
    o_valid = i_a_valid | i_b_valid;
    if (w_sel == SEL_B) begin
      o_late = i_b_late;
      o_prio = i_b_prio;
      o_idx  = i_b_idx;
    end else begin
      o_late = i_a_late;
      o_prio = i_a_prio;
      o_idx  = i_a_idx;
    end
    if (!o_valid) begin
      o_late = 1'b0;
      o_prio = '0;
      o_idx  = '0;
    end
  end

endmodule

// File: rtl/irq_arbiter_pipe.sv
// Pipelined earliest-deadline tournament arbiter with valid/ready output,
// flush, and optional round-robin tie-breaking.
module irq_arbiter_pipe
  import irq_arb_pkg::*;
#(
  parameter int unsigned NrInputs   = 32,
  parameter int unsigned PrioWidth  = 8,
  parameter int unsigned PipeStride = 2,
  parameter bit          SignedPrio = 1'b1,
  parameter bit          RrTie      = 1'b1,
  localparam int unsigned IdxWidth  = (NrInputs > 2) ? $clog2(NrInputs) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrInputs-1:0]                 valid_i,
  input  logic [NrInputs-1:0][PrioWidth-1:0]  prio_i,
  input  logic                                flush_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [PrioWidth-1:0]                prio_o,
  output logic [IdxWidth-1:0]                 idx_o
);

  localparam int unsigned Levels    = IdxWidth;
  localparam int unsigned NrLeaves  = 1 << IdxWidth;
  localparam int unsigned StrideDiv = (PipeStride > 0) ? PipeStride : 1;

  typedef struct packed {
    logic [PrioWidth-1:0] prio;
    logic [IdxWidth-1:0]  idx;
    logic                 valid;
    logic                 late;
  } node_t;

  // Heap layout: position 1 is the root, children of p are 2p and 2p+1,
  // leaves occupy NrLeaves .. 2*NrLeaves-1 in line-index order.
  node_t               w_tree [1:2*NrLeaves-1];
  logic                w_advance;
  logic [IdxWidth-1:0] r_rr_ptr;

  assign valid_o   = w_tree[1].valid;
  assign prio_o    = w_tree[1].prio;
  assign idx_o     = w_tree[1].idx;
  assign w_advance = ready_i | ~valid_o;

  // Leaves: pad lines never request; reset masks requests so an unregistered
  // configuration also shows an empty result while held in reset.
  for (genvar k = 0; k < NrLeaves; k++) begin : g_leaf
    if (k < NrInputs) begin : g_real
      assign w_tree[NrLeaves+k] = (valid_i[k] && rst_ni)
        ? '{prio:  prio_i[k],
            idx:   IdxWidth'(k),
            valid: 1'b1,
            late:  RrTie && (IdxWidth'(k) < r_rr_ptr)}
        : '0;
    end else begin : g_pad
      assign w_tree[NrLeaves+k] = '0;
    end
  end

  for (genvar j = 1; j <= Levels; j++) begin : g_lvl
    localparam int unsigned NrNodes = NrLeaves >> j;
    localparam bit          IsReg   = (PipeStride > 0) && ((j % StrideDiv) == 0);
    for (genvar k = 0; k < NrNodes; k++) begin : g_node
      localparam int unsigned P = NrNodes + k;
      logic                 w_v;
      logic                 w_l;
      logic [PrioWidth-1:0] w_p;
      logic [IdxWidth-1:0]  w_i;
      node_t                w_sel;

      irq_arb_node #(
        .PrioWidth (PrioWidth),
        .IdxWidth  (IdxWidth),
        .SignedPrio(SignedPrio)
      ) u_node (
        .i_a_valid(w_tree[2*P].valid),
        .i_a_late (w_tree[2*P].late),
        .i_a_prio (w_tree[2*P].prio),
        .i_a_idx  (w_tree[2*P].idx),
        .i_b_valid(w_tree[2*P+1].valid),
        .i_b_late (w_tree[2*P+1].late),
        .i_b_prio (w_tree[2*P+1].prio),
        .i_b_idx  (w_tree[2*P+1].idx),
        .o_valid  (w_v),
        .o_late   (w_l),
        .o_prio   (w_p),
        .o_idx    (w_i)
      );

      assign w_sel = '{prio: w_p, idx: w_i, valid: w_v, late: w_l};

      if (IsReg) begin : g_reg
        node_t r_node;
        // Stage register: flush empties it even while stalled, otherwise load on advance.
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            r_node <= '0;
          end else if (flush_i) begin
            r_node <= '0;
          end else if (w_advance) begin
            r_node <= w_sel;
          end
        end
        assign w_tree[P] = r_node;
      end else begin : g_comb
        assign w_tree[P] = w_sel;
      end
    end
  end

  // Round-robin pointer moves just past the line granted on each handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (valid_o && ready_i) begin
      r_rr_ptr <= (idx_o == IdxWidth'(NrInputs - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule
